// File: rtl/block_driver.sv
// Moving-block generator for one stacker row; sweeps, bounces, and runs the
// stop -> intersection handshake with find_intersection before spawning the next row.
module block_driver #(
   parameter int SCREEN_W   = 320,
   parameter int CELL_SHIFT = 3,
   parameter int INIT_SIZE  = 4,
   parameter int NUM_ROWS   = 15
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start_game,
   input  logic       stop_btn,
   input  logic       move_tick,
   input  logic       intersect_true,
   input  logic [8:0] inter_block_start,
   input  logic [8:0] inter_block_end,
   output logic       stop_true,
   output logic [8:0] curr_block_start,
   output logic [8:0] curr_block_end,
   output logic [3:0] curr_block_size,
   output logic [8:0] prev_block_start,
   output logic [8:0] prev_block_end,
   output logic [3:0] prev_block_size,
   output logic [3:0] row,
   output logic       game_over,
   output logic       game_won
);
   localparam int         CELL_W     = 1 << CELL_SHIFT;
   localparam logic [8:0] INIT_START = 9'((INIT_SIZE << CELL_SHIFT) - 1);

   typedef enum logic [2:0] {IDLE, MOVE, STOP, CHECK, OVER, WON} state_t;

   state_t     state;
   logic       dir_right;
   logic       stop_btn_q;
   logic       stop_edge;
   logic       step_right;
   logic [9:0] ov;
   logic [9:0] osize;
   logic       success;
   logic [8:0] next_start;
   logic [8:0] next_end;
   logic [3:0] next_size;
   logic [8:0] spawn_start;

   assign stop_edge = stop_btn & ~stop_btn_q;

   // Bounce decision: reverse when the next step would leave the screen.
   assign step_right = dir_right
                     ? !(({1'b0, curr_block_start} + 10'(CELL_W)) > 10'(SCREEN_W - 1))
                     : (curr_block_end < 9'(CELL_W));

   assign ov    = {1'b0, inter_block_start} - {1'b0, inter_block_end} + 10'd1;
   assign osize = ov >> CELL_SHIFT;

   // Row 0 has nothing beneath it, so it always lands in full.
   always_comb begin
      next_start = curr_block_start;
      next_end   = curr_block_end;
      next_size  = curr_block_size;
      success    = 1'b1;
      if (row != 4'd0) begin
         next_start = inter_block_start;
         next_end   = inter_block_end;
         next_size  = osize[3:0];
         success    = intersect_true && (inter_block_start >= inter_block_end)
                      && (osize != 10'd0);
      end
   end

   assign spawn_start = ({5'd0, next_size} << CELL_SHIFT) - 9'd1;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state            <= IDLE;
         dir_right        <= 1'b1;
         stop_btn_q       <= 1'b0;
         stop_true        <= 1'b0;
         curr_block_start <= '0;
         curr_block_end   <= '0;
         curr_block_size  <= '0;
         prev_block_start <= '0;
         prev_block_end   <= '0;
         prev_block_size  <= '0;
         row              <= '0;
         game_over        <= 1'b0;
         game_won         <= 1'b0;
      end else begin
         stop_btn_q <= stop_btn;
         stop_true  <= 1'b0;
         case (state)
            IDLE, OVER, WON: begin
               if (start_game) begin
                  state            <= MOVE;
                  row              <= '0;
                  curr_block_size  <= 4'(INIT_SIZE);
                  curr_block_end   <= '0;
                  curr_block_start <= INIT_START;
                  prev_block_start <= '0;
                  prev_block_end   <= '0;
                  prev_block_size  <= '0;
                  dir_right        <= 1'b1;
                  game_over        <= 1'b0;
                  game_won         <= 1'b0;
               end
            end
            MOVE: begin
               if (stop_edge) begin
                  state     <= STOP;
                  stop_true <= 1'b1;
               end else if (move_tick) begin
                  dir_right <= step_right;
                  if (step_right) begin
                     curr_block_start <= curr_block_start + 9'(CELL_W);
                     curr_block_end   <= curr_block_end + 9'(CELL_W);
                  end else begin
                     curr_block_start <= curr_block_start - 9'(CELL_W);
                     curr_block_end   <= curr_block_end - 9'(CELL_W);
                  end
               end
            end
            STOP: state <= CHECK;
            CHECK: begin
               if (!success) begin
                  state     <= OVER;
                  game_over <= 1'b1;
               end else begin
                  prev_block_start <= next_start;
                  prev_block_end   <= next_end;
                  prev_block_size  <= next_size;
                  if (row == 4'(NUM_ROWS - 1)) begin
                     state    <= WON;
                     game_won <= 1'b1;
                  end else begin
                     row              <= row + 4'd1;
                     curr_block_end   <= '0;
                     curr_block_size  <= next_size;
                     curr_block_start <= spawn_start;
                     dir_right        <= 1'b1;
                     state            <= MOVE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_block_driver.sv
// Randomised and directed bench for block_driver with a cell-level game model
// feeding a per-cycle scoreboard, plus named spot checks.
module tb_block_driver;
   localparam int SW    = 320;
   localparam int CELL  = 8;
   localparam int ISZ   = 4;
   localparam int NROWS = 3;

   logic       clk = 1'b0;
   logic       resetn = 1'b0, start_game = 1'b0, stop_btn = 1'b0, move_tick = 1'b0;
   logic       intersect_true = 1'b0;
   logic [8:0] inter_block_start = '0, inter_block_end = '0;
   logic       stop_true;
   logic [8:0] curr_block_start, curr_block_end, prev_block_start, prev_block_end;
   logic [3:0] curr_block_size, prev_block_size, row;
   logic       game_over, game_won;

   block_driver #(.SCREEN_W(SW), .CELL_SHIFT(3), .INIT_SIZE(ISZ), .NUM_ROWS(NROWS)) dut (
      .clk(clk), .resetn(resetn), .start_game(start_game), .stop_btn(stop_btn),
      .move_tick(move_tick), .intersect_true(intersect_true),
      .inter_block_start(inter_block_start), .inter_block_end(inter_block_end),
      .stop_true(stop_true), .curr_block_start(curr_block_start),
      .curr_block_end(curr_block_end), .curr_block_size(curr_block_size),
      .prev_block_start(prev_block_start), .prev_block_end(prev_block_end),
      .prev_block_size(prev_block_size), .row(row),
      .game_over(game_over), .game_won(game_won));

   always #5 clk = ~clk;

   typedef struct packed {
      logic       st;
      logic [8:0] cs, ce;
      logic [3:0] sz;
      logic [8:0] ps, pe;
      logic [3:0] psz;
      logic [3:0] rw;
      logic       ov, wn;
   } snap_t;

   snap_t sb_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   // Model: game phase plus block kept as cell position and size.
   typedef enum int {P_IDLE, P_PLAY, P_REQ, P_JUDGE, P_LOST, P_WON} phase_t;
   phase_t m_phase = P_IDLE;
   int m_cs = 0, m_ce = 0, m_sz = 0, m_ps = 0, m_pe = 0, m_psz = 0, m_row = 0;
   bit m_right = 1, m_btn_q = 0;

   function automatic string fmt(snap_t s);
      return $sformatf("st=%0d curr=(%0d,%0d,%0d) prev=(%0d,%0d,%0d) row=%0d over=%0d won=%0d",
                       s.st, s.cs, s.ce, s.sz, s.ps, s.pe, s.psz, s.rw, s.ov, s.wn);
   endfunction

   function automatic snap_t dut_snap();
      snap_t s;
      s = '{stop_true, curr_block_start, curr_block_end, curr_block_size, prev_block_start,
            prev_block_end, prev_block_size, row, game_over, game_won};
      return s;
   endfunction

   function automatic snap_t model_snap();
      snap_t s;
      s = '{m_phase == P_REQ, 9'(m_cs), 9'(m_ce), 4'(m_sz), 9'(m_ps), 9'(m_pe), 4'(m_psz),
            4'(m_row), m_phase == P_LOST, m_phase == P_WON};
      return s;
   endfunction

   task automatic place(int pos, int size);
      m_sz = size;
      m_ce = pos * CELL;
      m_cs = m_ce + size * CELL - 1;
   endtask

   task automatic model_step();
      bit edge_seen;
      int pos, ibs, ibe, nsz;
      bit ok;
      edge_seen = stop_btn && !m_btn_q;
      if (!resetn) begin
         m_phase = P_IDLE; m_right = 1; m_btn_q = 0;
         m_cs = 0; m_ce = 0; m_sz = 0; m_ps = 0; m_pe = 0; m_psz = 0; m_row = 0;
         return;
      end
      m_btn_q = stop_btn;
      case (m_phase)
         P_IDLE, P_LOST, P_WON:
            if (start_game) begin
               m_phase = P_PLAY; m_row = 0; place(0, ISZ);
               m_ps = 0; m_pe = 0; m_psz = 0; m_right = 1;
            end
         P_PLAY:
            if (edge_seen) m_phase = P_REQ;
            else if (move_tick) begin
               pos = m_ce / CELL;
               if (m_right && pos + m_sz >= SW / CELL) m_right = 0;
               else if (!m_right && pos == 0) m_right = 1;
               place(m_right ? pos + 1 : pos - 1, m_sz);
            end
         P_REQ: m_phase = P_JUDGE;
         P_JUDGE: begin
            ibs = int'(inter_block_start);
            ibe = int'(inter_block_end);
            if (m_row == 0) begin
               ok = 1; ibs = m_cs; ibe = m_ce; nsz = m_sz;
            end else begin
               nsz = (ibs >= ibe) ? (ibs - ibe + 1) / CELL : 0;
               ok  = intersect_true && nsz > 0;
            end
            if (!ok) m_phase = P_LOST;
            else begin
               m_ps = ibs; m_pe = ibe; m_psz = nsz;
               if (m_row == NROWS - 1) m_phase = P_WON;
               else begin
                  m_row++; place(0, nsz); m_right = 1; m_phase = P_PLAY;
               end
            end
         end
         default: m_phase = P_IDLE;
      endcase
   endtask

   task automatic cycle(bit rn = 1, bit sg = 0, bit sb = 0, bit mt = 0,
                        bit it = 0, int ibs = 0, int ibe = 0);
      snap_t e;
      resetn = rn; start_game = sg; stop_btn = sb; move_tick = mt;
      intersect_true = it; inter_block_start = 9'(ibs); inter_block_end = 9'(ibe);
      model_step();
      e = model_snap();
      @(posedge clk);
      sb_q.push_back(e);
      #1;
   endtask

   task automatic tick();
      cycle(1, 0, 0, 1);
   endtask

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Press, let the request cycle pass, then present the intersection result.
   task automatic do_stop(bit it, int ibs, int ibe);
      cycle(1, 0, 1);
      check("stop_true_high", int'(stop_true), 1);
      cycle(1, 0, 0);
      check("stop_true_one_cycle", int'(stop_true), 0);
      cycle(1, 0, 0, 0, it, ibs, ibe);
   endtask

   task automatic check_curr(string name, int s, int e, int sz);
      check({name, "_start"}, int'(curr_block_start), s);
      check({name, "_end"}, int'(curr_block_end), e);
      check({name, "_size"}, int'(curr_block_size), sz);
   endtask

   always @(negedge clk) begin
      snap_t exp, act;
      if (sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         act = dut_snap();
         n_checks++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL cycle_cmp: got %s expected %s", fmt(act), fmt(exp));
         end
      end
   end

   initial begin
      int hi, lo, ibs, ibe;
      bit it;
      cycle(0); cycle(0);
      check("reset_row", int'(row), 0);
      check("reset_curr_start", int'(curr_block_start), 0);

      cycle(1, 1);
      repeat (3) tick();
      check_curr("t1", 55, 24, 4);
      check("t1_row", int'(row), 0);

      repeat (33) tick();
      check_curr("t2_right_edge", 319, 288, 4);
      tick();
      check_curr("t2_bounce_left", 311, 280, 4);
      repeat (35) tick();
      check_curr("t2_left_edge", 31, 0, 4);
      tick();
      check_curr("t2_bounce_right", 39, 8, 4);
      repeat (2) tick();

      do_stop(0, 0, 0);
      check("t3_prev_start", int'(prev_block_start), 55);
      check("t3_prev_end", int'(prev_block_end), 24);
      check("t3_prev_size", int'(prev_block_size), 4);
      check("t3_row", int'(row), 1);
      check_curr("t3_spawn", 31, 0, 4);

      repeat (8) tick();
      check_curr("t5_pos", 95, 64, 4);
      do_stop(0, 55, 24);
      check("t5_over", int'(game_over), 1);
      repeat (3) tick();
      cycle(1, 0, 1, 1); cycle(1, 0, 0);
      check_curr("t5_hold", 95, 64, 4);
      check("t5_still_over", int'(game_over), 1);
      cycle(1, 1);
      check("t5_restart_over", int'(game_over), 0);
      check("t5_restart_row", int'(row), 0);
      check_curr("t5_restart", 31, 0, 4);

      repeat (3) tick();
      do_stop(0, 0, 0);
      check("g2_row", int'(row), 1);
      repeat (2) tick();
      check_curr("t4_pos", 47, 16, 4);
      do_stop(1, 47, 24);
      check("t4_prev_start", int'(prev_block_start), 47);
      check("t4_prev_end", int'(prev_block_end), 24);
      check("t4_prev_size", int'(prev_block_size), 3);
      check("t4_row", int'(row), 2);
      check_curr("t4_spawn", 23, 0, 3);
      do_stop(1, 23, 0);
      check("t6_won", int'(game_won), 1);
      check("t6_won_row", int'(row), 2);

      cycle(1, 1);
      check("t6_restart_won", int'(game_won), 0);
      cycle(1, 0, 1, 1);
      check("t6_coinc_stop", int'(stop_true), 1);
      check_curr("t6_coinc_nomove", 31, 0, 4);
      cycle(1, 0, 1);
      cycle(0, 0, 1, 0, 1, 31, 0);
      check("t6_rst_stop", int'(stop_true), 0);
      check("t6_rst_start", int'(curr_block_start), 0);
      check("t6_rst_size", int'(curr_block_size), 0);
      check("t6_rst_prev", int'(prev_block_start), 0);
      check("t6_rst_row", int'(row), 0);

      cycle(1, 1);
      for (int i = 0; i < 3000; i++) begin
         hi = (m_cs < m_ps) ? m_cs : m_ps;
         lo = (m_ce > m_pe) ? m_ce : m_pe;
         if ($urandom % 4 != 0) begin
            it = (hi >= lo); ibs = hi; ibe = lo;
         end else begin
            it  = 1'($urandom);
            ibe = $urandom_range(0, 300);
            ibs = ibe + int'($urandom_range(0, 100)) - 20;
            if (ibs < 0) ibs = 0;
         end
         cycle(($urandom % 400) != 0, ($urandom % 50) == 0, ($urandom % 6) == 0,
               1'($urandom), it, ibs, ibe);
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
